// File: rtl/piano_pkg.sv
// Shared definitions for the piano datapath: note codes, song entry layout,
// sequencer states, mode codes and the constant song image.
package piano_pkg;

    localparam int NOTE_W  = 4;
    localparam int OCT_W   = 2;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = NOTE_W + OCT_W + DUR_W;
    localparam int LED_W   = 7;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_SO   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_SI   = 4'd7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        mode_free,
        mode_auto,
        mode_learn
    } mode_t;

    // One ROM word: {note, octave, dur}; dur == 0 marks the end of a song.
    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  octave;
        logic [DUR_W-1:0]  dur;
    } rom_entry_t;

    // One-hot LED pattern for a note: bit (note-1), nothing for a rest or an
    // out-of-range code.
    function automatic logic [LED_W-1:0] note_to_led(input logic [NOTE_W-1:0] note);
        logic [LED_W-1:0] led;
        led = '0;
        if (note >= NOTE_DO && note <= NOTE_SI) begin
            led[3'(note - NOTE_DO)] = 1'b1;
        end
        return led;
    endfunction

    // Song memory image, indexed by song number and entry index. Song 3 fills
    // all 64 slots and has no end marker, so playback stops at the last slot.
    function automatic rom_entry_t song_image(input logic [1:0] song, input int unsigned idx);
        rom_entry_t e;
        e = '0;
        case (song)
            2'd0: begin
                case (idx)
                    0:       e = '{NOTE_DO, 2'd1, 4'd1};
                    1:       e = '{NOTE_RE, 2'd1, 4'd1};
                    2:       e = '{NOTE_MI, 2'd1, 4'd1};
                    default: e = '0;
                endcase
            end
            2'd1: begin
                case (idx)
                    0:       e = '{NOTE_MI, 2'd1, 4'd2};
                    1:       e = '{NOTE_SO, 2'd2, 4'd1};
                    default: e = '0;
                endcase
            end
            2'd2: begin
                case (idx)
                    0:       e = '{NOTE_DO, 2'd2, 4'd1};
                    1:       e = '{NOTE_SI, 2'd3, 4'd2};
                    2:       e = '{NOTE_FA, 2'd0, 4'd1};
                    default: e = '0;
                endcase
            end
            default: begin
                if (idx < 64) begin
                    e.note   = NOTE_W'(idx % 7 + 1);
                    e.octave = OCT_W'(idx % 4);
                    e.dur    = DUR_W'(idx % 3 + 1);
                end
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Synchronous song ROM: four songs of 2^ADDR_W entries, one-cycle read latency.
module song_rom
    import piano_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W+1:0]   addr,
    output logic [ENTRY_W-1:0]  data
);

    // Registered read of the constant song image; address is {song, pointer}.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= song_image(addr[ADDR_W+1:ADDR_W], 32'(addr[ADDR_W-1:0]));
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play song sequencer: walks the song ROM and drives note, octave, LED,
// song number, busy and done for the auto mode path.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 16,
    parameter int GAP_TICKS = 1,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [1:0]        song_select,
    output logic [NOTE_W-1:0] note_out,
    output logic [OCT_W-1:0]  octave_out,
    output logic [LED_W-1:0]  led_out,
    output logic [3:0]        num,
    output logic              busy,
    output logic              done
);

    localparam int DIV_RAW  = CLK_HZ / TICK_HZ;
    localparam int DIV      = (DIV_RAW > 1) ? DIV_RAW : 1;
    localparam int PRESC_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W    = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : DUR_W;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    seq_state_t           state;
    seq_state_t           next_state;
    logic [ADDR_W-1:0]    ptr;
    logic [1:0]           song_idx;
    logic [PRESC_W-1:0]   presc;
    logic [CNT_W-1:0]     tick_cnt;
    logic [NOTE_W-1:0]    note_reg;
    logic [OCT_W-1:0]     oct_reg;
    logic [ENTRY_W-1:0]   rom_data;
    rom_entry_t           entry;
    logic                 active;
    logic                 tick;
    logic                 last_tick;
    logic                 advance;
    logic                 load_note;
    logic                 show_note;
    logic [NOTE_W-1:0]    next_note;
    logic [OCT_W-1:0]     next_oct;

    song_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  ({song_idx, ptr}),
        .data  (rom_data)
    );

    assign entry     = rom_entry_t'(rom_data);
    assign active    = (state == PLAY || state == GAP) && !pause;
    assign tick      = active && (presc == PRESC_LAST);
    assign last_tick = tick && (tick_cnt == CNT_W'(1));
    assign load_note = (state == LOAD) && (entry.dur != '0);
    assign num       = {2'b00, song_idx};

    // Next-state decode; stop beats everything, and an advance past the last
    // slot of a song ends it instead of wrapping the pointer.
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        if (stop && state != IDLE) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (start && !stop) next_state = FETCH;
                FETCH: next_state = LOAD;
                LOAD:  next_state = (entry.dur == '0) ? DONE : PLAY;
                PLAY: begin
                    if (last_tick) begin
                        if (GAP_TICKS > 0) next_state = GAP;
                        else               advance    = 1'b1;
                    end
                end
                GAP:   if (last_tick) advance = 1'b1;
                DONE:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
            if (advance) begin
                next_state = (&ptr) ? DONE : FETCH;
            end
        end
    end

    // Values the output registers will present after this edge.
    always_comb begin
        next_note = load_note ? entry.note   : note_reg;
        next_oct  = load_note ? entry.octave : oct_reg;
        show_note = (next_state == PLAY) && !pause;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Song index latch and ROM pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            song_idx <= '0;
            ptr      <= '0;
        end else if (state == IDLE && next_state == FETCH) begin
            song_idx <= song_select;
            ptr      <= '0;
        end else if (advance && next_state == FETCH) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Tick prescaler: runs only in PLAY/GAP, freezes under pause, and sits at
    // zero everywhere else so each note starts on a fresh tick period.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (state == PLAY || state == GAP) begin
            if (!pause) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
        end else begin
            presc <= '0;
        end
    end

    // Remaining ticks of the current note or gap.
    always_ff @(posedge clk) begin
        if (reset || next_state == IDLE) begin
            tick_cnt <= '0;
        end else if (load_note) begin
            tick_cnt <= CNT_W'(entry.dur);
        end else if (tick) begin
            if (state == PLAY && last_tick && GAP_TICKS > 0) tick_cnt <= CNT_W'(GAP_TICKS);
            else                                             tick_cnt <= tick_cnt - 1'b1;
        end
    end

    // Current note and octave, captured when a valid entry is loaded.
    always_ff @(posedge clk) begin
        if (reset || next_state == IDLE) begin
            note_reg <= '0;
            oct_reg  <= '0;
        end else if (load_note) begin
            note_reg <= entry.note;
            oct_reg  <= entry.octave;
        end
    end

    // Registered outputs; the note and LED only show while playing unpaused.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_out   <= '0;
            led_out    <= '0;
            octave_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            note_out   <= show_note ? next_note : NOTE_REST;
            led_out    <= show_note ? note_to_led(next_note) : '0;
            octave_out <= (next_state == IDLE) ? '0 : next_oct;
            busy       <= (next_state != IDLE);
            done       <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer against a segment-timeline model.
module tb_song_sequencer;

    localparam int CLK_HZ       = 40;
    localparam int TICK_HZ      = 10;
    localparam int GAP_TICKS    = 1;
    localparam int ADDR_W       = 6;
    localparam int CYC_PER_TICK = CLK_HZ / TICK_HZ;

    localparam int K_OVH  = 0;
    localparam int K_NOTE = 1;
    localparam int K_GAP  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int kind;
        int len;
        int note;
        int oct;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] song_select = 2'd0;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [3:0] num;
    logic       busy;
    logic       done;

    seg_t segs[$];
    int   m_num = 0;
    int   m_oct = 0;
    int   exp_note, exp_oct, exp_led, exp_busy, exp_done;
    int   checks = 0;
    int   errors = 0;
    int   guard;

    song_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .GAP_TICKS (GAP_TICKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .song_select (song_select),
        .note_out    (note_out),
        .octave_out  (octave_out),
        .led_out     (led_out),
        .num         (num),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Runaway guard.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed no finish required finish");
        $fatal(1, "[TB] watchdog");
    end

    // The songs as listed in the melody table: {note, octave, dur}, dur 0 = end.
    function automatic void song_note(input int song, input int i,
                                      output int note, output int oct, output int dur);
        note = 0; oct = 0; dur = 0;
        case (song)
            0: if (i < 3) begin note = i + 1; oct = 1; dur = 1; end
            1: begin
                if (i == 0)      begin note = 3; oct = 1; dur = 2; end
                else if (i == 1) begin note = 5; oct = 2; dur = 1; end
            end
            2: begin
                if (i == 0)      begin note = 1; oct = 2; dur = 1; end
                else if (i == 1) begin note = 7; oct = 3; dur = 2; end
                else if (i == 2) begin note = 4; oct = 0; dur = 1; end
            end
            default: if (i < 64) begin note = i % 7 + 1; oct = i % 4; dur = i % 3 + 1; end
        endcase
    endfunction

    // Expand a song into its timeline: 2 fetch/load cycles per entry, the note,
    // its gap, and a final done cycle (no fetch if the song fills all slots).
    task automatic build_song(input int song);
        int n, o, d;
        segs.delete();
        for (int i = 0; i < 64; i++) begin
            song_note(song, i, n, o, d);
            segs.push_back('{K_OVH, 2, 0, 0});
            if (d == 0) begin
                segs.push_back('{K_DONE, 1, 0, 0});
                return;
            end
            segs.push_back('{K_NOTE, d * CYC_PER_TICK, n, o});
            if (GAP_TICKS > 0) segs.push_back('{K_GAP, GAP_TICKS * CYC_PER_TICK, 0, 0});
        end
        segs.push_back('{K_DONE, 1, 0, 0});
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_update();
        seg_t f;
        if (reset) begin
            segs.delete();
            m_num = 0;
            m_oct = 0;
        end else if (segs.size() == 0) begin
            if (start && !stop) begin
                build_song(int'(song_select));
                m_num = int'(song_select);
                m_oct = 0;
            end
        end else if (stop) begin
            segs.delete();
        end else begin
            f = segs[0];
            if (!(pause && (f.kind == K_NOTE || f.kind == K_GAP))) begin
                f.len = f.len - 1;
                if (f.len == 0) void'(segs.pop_front());
                else            segs[0] = f;
            end
        end
        exp_note = 0; exp_led = 0; exp_busy = 0; exp_done = 0;
        if (segs.size() == 0) begin
            m_oct = 0;
        end else begin
            exp_busy = 1;
            f = segs[0];
            if (f.kind == K_NOTE) begin
                m_oct = f.oct;
                if (!pause) begin
                    exp_note = f.note;
                    exp_led  = (f.note == 0) ? 0 : (1 << (f.note - 1));
                end
            end
            if (f.kind == K_DONE) exp_done = 1;
        end
        exp_oct = m_oct;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_output();
        check_val("note_out",   32'(note_out),   32'(exp_note));
        check_val("octave_out", 32'(octave_out), 32'(exp_oct));
        check_val("led_out",    32'(led_out),    32'(exp_led));
        check_val("num",        32'(num),        32'(m_num));
        check_val("busy",       32'(busy),       32'(exp_busy));
        check_val("done",       32'(done),       32'(exp_done));
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic st,
                                  input logic p, input logic [1:0] sel);
        reset       = r;
        start       = s;
        stop        = st;
        pause       = p;
        song_select = sel;
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_output();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (segs.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (segs.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout observed %0d cycles required end of song", tag, n);
        end
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        run_cycles(3);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        run_cycles(2);

        // Song 1 with a single start pulse.
        $display("[TB] song 1 plain");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        run_to_idle("song1", 200);
        run_cycles(3);

        // Song 1 with a 20-cycle pause inside the first note.
        $display("[TB] song 1 pause");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        run_cycles(4);
        pause = 1'b1;
        run_cycles(20);
        pause = 1'b0;
        run_to_idle("song1_pause", 200);

        // Stop together with start in IDLE, then stop mid-note.
        $display("[TB] stop cases");
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        step();
        check_val("stop_start_busy", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        run_cycles(5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_cycles(6);

        // Song select changed while busy is ignored.
        $display("[TB] song 2 select change");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        run_cycles(10);
        song_select = 2'd0;
        run_to_idle("song2", 300);

        // Full 64-entry song with no end marker.
        $display("[TB] song 3 full length");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        run_to_idle("song3", 2000);
        run_cycles(4);

        // Reset while in a gap, then replay from the first entry.
        $display("[TB] reset mid gap");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        guard = 0;
        while (segs.size() != 0 && segs[0].kind != K_GAP && guard < 100) begin
            step();
            guard++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        run_to_idle("replay", 200);

        // Randomized runs: random songs, pauses, ignored starts and selects,
        // occasional stops.
        $display("[TB] random runs");
        for (int iter = 0; iter < 8; iter++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
            step();
            guard = 0;
            do begin
                start       = ($urandom_range(0, 9) == 0);
                song_select = 2'($urandom_range(0, 3));
                stop        = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 11) == 0) pause = ~pause;
                step();
                guard++;
            end while (segs.size() != 0 && guard < 6000);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            run_to_idle("random", 10);
            run_cycles(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
